// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit add/subtract; carry/borrow output only with ADDSUB_FLAGS_EN.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef ADDSUB_FLAGS_EN
  output logic             flag_o,
`endif
  output logic [WIDTH-1:0] res_o
);

`ifdef ADDSUB_FLAGS_EN
  // One extra bit: carry-out for add, borrow (a<b) for sub.
  logic [WIDTH:0] wide;

  always_comb begin
    wide = '0;
    if (sel_i == OP_SUB) wide = {1'b0, a_i} - {1'b0, b_i};
    else                 wide = {1'b0, a_i} + {1'b0, b_i};
  end

  assign res_o  = wide[WIDTH-1:0];
  assign flag_o = wide[WIDTH];
`else
  always_comb begin
    res_o = '0;
    if (sel_i == OP_SUB) res_o = a_i - b_i;
    else                 res_o = a_i + b_i;
  end
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between two requesters.
// Optional res_flag port (carry/borrow) enabled by ADDSUB_FLAGS_EN.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
`ifdef ADDSUB_FLAGS_EN
  output logic             res_flag,
`endif
  output logic [WIDTH-1:0] res_data
);

  state_e           state_q;
  logic             last_grant_q;
  logic             sel_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             res_valid_q;
  logic             res_id_q;
  logic [WIDTH-1:0] res_data_q;
  logic [WIDTH-1:0] unit_res;

  logic grant_d;
  logic winner_d;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    grant_d  = (state_q == IDLE) && en && !rst && (req0_valid || req1_valid);
    winner_d = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  end

  assign req0_ready = grant_d && !winner_d;
  assign req1_ready = grant_d &&  winner_d;

`ifdef ADDSUB_FLAGS_EN
  logic res_flag_q;
  logic unit_flag;

  addsub_unit #(.WIDTH(WIDTH)) u_unit (
    .sel_i  (sel_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .flag_o (unit_flag),
    .res_o  (unit_res)
  );

  always_ff @(posedge clk) begin
    if (rst)                    res_flag_q <= 1'b0;
    else if (state_q == EXEC)   res_flag_q <= unit_flag;
  end

  assign res_flag = res_flag_q;
`else
  addsub_unit #(.WIDTH(WIDTH)) u_unit (
    .sel_i (sel_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (unit_res)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            last_grant_q <= winner_d;
            id_q         <= winner_d;
            sel_q        <= winner_d ? req1_sel : req0_sel;
            a_q          <= winner_d ? req1_a   : req0_a;
            b_q          <= winner_d ? req1_b   : req0_b;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= unit_res;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule
